// File: rtl/audio_frame_scheduler.sv
// rtl/audio_frame_scheduler.sv - sample-rate scheduler sequencing mic capture and DAC frames
// One mic conversion followed by one DAC frame per sample tick, with timeouts and overrun counting.
module audio_frame_scheduler #(
   parameter int unsigned SAMPLE_DIV = 2268,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [2:0]  vol,
   output logic        mic_start,
   input  logic        mic_done,
   input  logic [11:0] mic_data,
   output logic        dac_start,
   input  logic        dac_done,
   output logic [11:0] dac_a,
   output logic [11:0] dac_b,
   output logic        busy,
   output logic [7:0]  overrun_cnt,
   output logic        timeout_err,
   output logic [15:0] frame_cnt
);

   localparam int          WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      MIC_REQ,
      MIC_WAIT,
      DAC_REQ,
      DAC_WAIT
   } state_t;

   state_t        r_state;
   logic [15:0]   r_div;
   logic [WW-1:0] r_wait;
   logic          r_mic_start;
   logic          r_dac_start;
   logic          r_busy;
   logic          r_timeout_err;
   logic [11:0]   r_dac_a;
   logic [11:0]   r_dac_b;
   logic [7:0]    r_overrun_cnt;
   logic [15:0]   r_frame_cnt;
   logic          w_tick;

   assign w_tick = enable && (r_div == DIV_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div <= '0;
      end else if (!enable || w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_wait        <= '0;
         r_mic_start   <= 1'b0;
         r_dac_start   <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_dac_a       <= '0;
         r_dac_b       <= '0;
         r_overrun_cnt <= '0;
         r_frame_cnt   <= '0;
      end else begin
         // Ticks only start frames from WAIT_TICK; anywhere else they are lost.
         if (w_tick && (r_state != WAIT_TICK) && (r_overrun_cnt != 8'hFF))
            r_overrun_cnt <= r_overrun_cnt + 8'd1;

         case (r_state)
            IDLE: begin
               if (enable)
                  r_state <= WAIT_TICK;
            end
            WAIT_TICK: begin
               if (w_tick) begin
                  r_state     <= MIC_REQ;
                  r_mic_start <= 1'b1;
                  r_busy      <= 1'b1;
               end else if (!enable) begin
                  r_state <= IDLE;
               end
            end
            MIC_REQ: begin
               r_mic_start <= 1'b0;
               r_wait      <= '0;
               r_state     <= MIC_WAIT;
            end
            MIC_WAIT: begin
               if (mic_done) begin
                  r_dac_a     <= mic_data;
                  r_dac_b     <= mic_data >> vol;
                  r_dac_start <= 1'b1;
                  r_state     <= DAC_REQ;
               end else if (r_wait == WAIT_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= enable ? WAIT_TICK : IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            DAC_REQ: begin
               r_dac_start <= 1'b0;
               r_wait      <= '0;
               r_state     <= DAC_WAIT;
            end
            DAC_WAIT: begin
               if (dac_done) begin
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                  r_busy      <= 1'b0;
                  r_state     <= enable ? WAIT_TICK : IDLE;
               end else if (r_wait == WAIT_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= enable ? WAIT_TICK : IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_mic_start <= 1'b0;
               r_dac_start <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign mic_start   = r_mic_start;
   assign dac_start   = r_dac_start;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;
   assign dac_a       = r_dac_a;
   assign dac_b       = r_dac_b;
   assign overrun_cnt = r_overrun_cnt;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// tb/tb_audio_frame_scheduler.sv - directed self-checking bench for audio_frame_scheduler
// Three instances: nominal divider, short divider, and short divider with short timeout.
module tb_audio_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  en;
   logic [2:0]  vol;
   logic        mic_done;
   logic [11:0] mic_data;
   logic        dac_done;
   logic [2:0]  ms, ds, bsy, te;
   logic [11:0] da [3];
   logic [11:0] db [3];
   logic [7:0]  ov [3];
   logic [15:0] fc [3];

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int t_rel;
   int msc [3] = '{0, 0, 0};
   int dsc [3] = '{0, 0, 0};

   typedef struct {
      logic [2:0]  vol;
      logic [11:0] data;
      logic [11:0] exp_a;
      logic [11:0] exp_b;
   } vec_t;
   vec_t vt [14];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ms[d] === 1'b1) msc[d] = msc[d] + 1;
         if (ds[d] === 1'b1) dsc[d] = dsc[d] + 1;
      end
   end

   audio_frame_scheduler #(.SAMPLE_DIV(100), .TIMEOUT(1024)) u0 (
      .clk(clk), .rst(rst), .enable(en[0]), .vol(vol),
      .mic_start(ms[0]), .mic_done(mic_done), .mic_data(mic_data),
      .dac_start(ds[0]), .dac_done(dac_done), .dac_a(da[0]), .dac_b(db[0]),
      .busy(bsy[0]), .overrun_cnt(ov[0]), .timeout_err(te[0]), .frame_cnt(fc[0]));

   audio_frame_scheduler #(.SAMPLE_DIV(64), .TIMEOUT(1024)) u1 (
      .clk(clk), .rst(rst), .enable(en[1]), .vol(vol),
      .mic_start(ms[1]), .mic_done(mic_done), .mic_data(mic_data),
      .dac_start(ds[1]), .dac_done(dac_done), .dac_a(da[1]), .dac_b(db[1]),
      .busy(bsy[1]), .overrun_cnt(ov[1]), .timeout_err(te[1]), .frame_cnt(fc[1]));

   audio_frame_scheduler #(.SAMPLE_DIV(64), .TIMEOUT(16)) u2 (
      .clk(clk), .rst(rst), .enable(en[2]), .vol(vol),
      .mic_start(ms[2]), .mic_done(mic_done), .mic_data(mic_data),
      .dac_start(ds[2]), .dac_done(dac_done), .dac_a(da[2]), .dac_b(db[2]),
      .busy(bsy[2]), .overrun_cnt(ov[2]), .timeout_err(te[2]), .frame_cnt(fc[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input int d, input string tag);
      chk({tag, "_mic_start"}, 32'(ms[d]), 0);
      chk({tag, "_dac_start"}, 32'(ds[d]), 0);
      chk({tag, "_busy"}, 32'(bsy[d]), 0);
      chk({tag, "_timeout_err"}, 32'(te[d]), 0);
      chk({tag, "_dac_a"}, 32'(da[d]), 0);
      chk({tag, "_dac_b"}, 32'(db[d]), 0);
      chk({tag, "_overrun_cnt"}, 32'(ov[d]), 0);
      chk({tag, "_frame_cnt"}, 32'(fc[d]), 0);
   endtask

   task automatic do_reset(input logic [2:0] en_v);
      @(negedge clk);
      rst = 1'b0;
      en = 3'b000;
      mic_done = 1'b0;
      dac_done = 1'b0;
      step(2);
      en = en_v;
      rst = 1'b1;
      t_rel = cyc;
   endtask

   task automatic wait_ms(input int d, input int bound);
      bit ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (ms[d] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL wait_mic_start dut%0d: none within %0d cycles", d, bound);
      end
   endtask

   task automatic mic_pulse(input logic [11:0] d, input logic [2:0] v);
      vol = v;
      mic_data = d;
      mic_done = 1'b1;
      step(1);
      mic_done = 1'b0;
   endtask

   task automatic dac_pulse();
      dac_done = 1'b1;
      step(1);
      dac_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_t;
      int c;
      int d0;

      vt[0]  = '{3'd2, 12'hCDE, 12'hCDE, 12'h337};
      vt[1]  = '{3'd0, 12'h3FC, 12'h3FC, 12'h3FC};
      vt[2]  = '{3'd1, 12'hE63, 12'hE63, 12'h731};
      vt[3]  = '{3'd7, 12'hFFF, 12'hFFF, 12'h01F};
      vt[4]  = '{3'd3, 12'h000, 12'h000, 12'h000};
      vt[5]  = '{3'd4, 12'h800, 12'h800, 12'h080};
      vt[6]  = '{3'd5, 12'h123, 12'h123, 12'h009};
      vt[7]  = '{3'd6, 12'hABC, 12'hABC, 12'h02A};
      vt[8]  = '{3'd1, 12'h555, 12'h555, 12'h2AA};
      vt[9]  = '{3'd3, 12'hAAA, 12'hAAA, 12'h155};
      vt[10] = '{3'd2, 12'h7FF, 12'h7FF, 12'h1FF};
      vt[11] = '{3'd0, 12'h001, 12'h001, 12'h001};
      vt[12] = '{3'd7, 12'hFED, 12'hFED, 12'h01F};
      vt[13] = '{3'd4, 12'h9C4, 12'h9C4, 12'h09C};

      rst = 1'b0;
      en = 3'b000;
      vol = 3'd0;
      mic_done = 1'b0;
      mic_data = 12'h000;
      dac_done = 1'b0;
      step(3);
      chk_zero(0, "reset");

      // Back-to-back nominal frames on the 100-cycle divider.
      do_reset(3'b001);
      prev_t = 0;
      for (int i = 0; i < 14; i++) begin
         wait_ms(0, 150);
         if (i == 0) chk("first_tick_latency", 32'(cyc - t_rel), 100);
         else begin
            chk("mic_start_spacing", 32'(cyc - prev_t), 100);
            chk("dac_a_held", 32'(da[0]), 32'(vt[i-1].exp_a));
         end
         prev_t = cyc;
         chk("busy_in_frame", 32'(bsy[0]), 1);
         step(20);
         chk("dac_start_before_done", 32'(ds[0]), 0);
         mic_pulse(vt[i].data, vt[i].vol);
         chk("dac_start_after_mic_done", 32'(ds[0]), 1);
         chk("dac_a", 32'(da[0]), 32'(vt[i].exp_a));
         chk("dac_b", 32'(db[0]), 32'(vt[i].exp_b));
         step(40);
         dac_pulse();
         chk("frame_cnt", 32'(fc[0]), 32'(i + 1));
      end
      chk("b2b_overrun_cnt", 32'(ov[0]), 0);
      chk("b2b_timeout_err", 32'(te[0]), 0);
      chk("b2b_busy_idle", 32'(bsy[0]), 0);

      // Reset in DAC_WAIT clears everything without waiting for a clock edge.
      wait_ms(0, 150);
      step(5);
      mic_pulse(12'h456, 3'd1);
      step(3);
      chk("busy_dac_wait", 32'(bsy[0]), 1);
      #2;
      rst = 1'b0;
      #1;
      chk_zero(0, "async_reset");

      // enable dropped in MIC_WAIT: frame completes, then IDLE.
      do_reset(3'b001);
      wait_ms(0, 150);
      step(3);
      en[0] = 1'b0;
      step(7);
      chk("dis_busy_mic_wait", 32'(bsy[0]), 1);
      mic_pulse(12'h2A5, 3'd1);
      chk("dis_dac_start", 32'(ds[0]), 1);
      chk("dis_dac_b", 32'(db[0]), 32'h152);
      step(10);
      dac_pulse();
      chk("dis_frame_cnt", 32'(fc[0]), 1);
      chk("dis_busy_low", 32'(bsy[0]), 0);
      c = msc[0];
      step(250);
      chk("dis_no_mic_start", 32'(msc[0] - c), 0);

      // Overrun: two ticks fall inside a long DAC_WAIT.
      do_reset(3'b010);
      c = msc[1];
      wait_ms(1, 100);
      step(5);
      mic_pulse(12'h3C3, 3'd0);
      chk("ovr_dac_start", 32'(ds[1]), 1);
      step(150);
      dac_pulse();
      chk("ovr_overrun_cnt", 32'(ov[1]), 2);
      chk("ovr_frame_cnt", 32'(fc[1]), 1);
      chk("ovr_single_mic_start", 32'(msc[1] - c), 1);
      wait_ms(1, 100);
      chk("ovr_next_tick_phase", 32'(cyc - t_rel), 256);

      // Coincident done/timeout, then a genuine mic timeout.
      do_reset(3'b100);
      wait_ms(2, 100);
      step(16);
      chk("coin_te_before", 32'(te[2]), 0);
      mic_pulse(12'hFFF, 3'd7);
      chk("coin_dac_start", 32'(ds[2]), 1);
      chk("coin_dac_a", 32'(da[2]), 32'hFFF);
      chk("coin_dac_b", 32'(db[2]), 32'h01F);
      chk("coin_timeout_err", 32'(te[2]), 0);
      step(5);
      dac_pulse();
      chk("coin_frame_cnt", 32'(fc[2]), 1);
      d0 = dsc[2];
      wait_ms(2, 100);
      chk("to_second_tick", 32'(cyc - t_rel), 128);
      step(16);
      chk("to_te_at_15", 32'(te[2]), 0);
      step(1);
      chk("to_te_at_16", 32'(te[2]), 1);
      chk("to_busy_low", 32'(bsy[2]), 0);
      step(1);
      mic_pulse(12'h111, 3'd0);
      chk("to_late_mic_done_dac_a", 32'(da[2]), 32'hFFF);
      chk("to_dac_b_kept", 32'(db[2]), 32'h01F);
      dac_pulse();
      chk("to_stray_dac_done", 32'(fc[2]), 1);
      chk("to_no_dac_start", 32'(dsc[2] - d0), 0);
      wait_ms(2, 100);
      chk("to_restart_tick", 32'(cyc - t_rel), 192);
      chk("to_te_sticky", 32'(te[2]), 1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
